// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the FIFO write arbiter: FSM encoding and default word width.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int unsigned FIFO_DATA_WIDTH = 16;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Circular first-one finder: lowest requesting index at or after ptr_i, wrapping around.
module rr_priority_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned slot;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    slot  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      slot = (32'(ptr_i) + k) % N;
      if (!any_o && req_i[slot]) begin
        gnt_o[slot] = 1'b1;
        idx_o       = PTR_W'(slot);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_ARB_BURST_EN to allow up to BURST_LEN words per grant; otherwise one word per grant.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                        Clk_In,
  input  logic                        Reset_N_In,
  input  logic [N_REQ-1:0]            Req_In,
  input  logic [N_REQ*DATA_WIDTH-1:0] Data_In,
  output logic [N_REQ-1:0]            Ack_Out,
  output logic [N_REQ-1:0]            Grant_Out,
  input  logic                        FIFO_Full_In,
  output logic                        FIFO_Write_Enable_Out,
  output logic [DATA_WIDTH-1:0]       FIFO_Data_Out
);

  localparam int unsigned PTR_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || BURST_LEN < 1 || BURST_LEN > 15) begin : g_param_check
    $error("fifo_write_arbiter: N_REQ or BURST_LEN out of range");
  end

  arb_state_e            state_q, state_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]      grant_q, grant_d;
  logic [N_REQ-1:0]      ack_q, ack_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [N_REQ-1:0]      pick_gnt;
  logic [PTR_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  owner_req;
  logic                  burst_done;
  logic [PTR_W-1:0]      ptr_after_owner;

  rr_priority_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i (Req_In),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign owner_req       = Req_In[owner_q];
  assign ptr_after_owner = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef FIFO_ARB_BURST_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A dropped request ends the burst even if the FIFO is full; full only stalls a live owner.
  assign burst_done = !owner_req || (cnt_q == CNT_W'(BURST_LEN));
`else
  assign burst_done = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ack_d   = '0;
    we_d    = 1'b0;
    data_d  = data_q;
`ifdef FIFO_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!FIFO_Full_In && pick_any) begin
          owner_d = pick_idx;
          grant_d = pick_gnt;
          ack_d   = pick_gnt;
          we_d    = 1'b1;
          data_d  = Data_In[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d = ST_BURST;
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      ST_BURST: begin
        if (burst_done) begin
          grant_d = '0;
          ptr_d   = ptr_after_owner;
          state_d = ST_IDLE;
        end else if (!FIFO_Full_In) begin
          ack_d   = grant_q;
          we_d    = 1'b1;
          data_d  = Data_In[owner_q*DATA_WIDTH +: DATA_WIDTH];
`ifdef FIFO_ARB_BURST_EN
          cnt_d   = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      data_q  <= data_d;
`ifdef FIFO_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign Ack_Out               = ack_q;
  assign Grant_Out             = grant_q;
  assign FIFO_Write_Enable_Out = we_q;
  assign FIFO_Data_Out         = data_q;

endmodule
